// File: rtl/stopwatch_bcd_if.sv
// Control pulses and BCD display outputs of the stopwatch.
// master drives the buttons, slave is the stopwatch itself.
interface stopwatch_bcd_if;
  logic        start_stop;
  logic        clear;
  logic        lap;
  logic [31:0] digits;
  logic        running;
  logic        wrap;

  modport master (output start_stop, clear, lap, input digits, running, wrap);
  modport slave  (input start_stop, clear, lap, output digits, running, wrap);
endinterface

// File: rtl/stopwatch_bcd.sv
// HH:MM:SS.cc BCD stopwatch feeding the 8-digit scan path.
// Define STOPWATCH_LAP_EN to add the lap freeze/snapshot display hold.
module stopwatch_bcd #(
  parameter int TICK_DIV = 1000000
) (
  input logic           clk,
  input logic           rst,
  stopwatch_bcd_if.slave bus
);

  localparam int PW = $clog2(TICK_DIV);
  localparam logic [PW-1:0] PRE_MAX = PW'(TICK_DIV - 1);
  // Per-digit maximum for hundredths, seconds and minutes, digit 0 in the low nibble.
  localparam logic [23:0] DIGIT_MAX = 24'h595999;

  typedef enum logic [1:0] {IDLE, RUN, PAUSE} state_t;

  state_t        state_reg, state_next;
  logic [PW-1:0] prescaler_reg, prescaler_next;
  logic [31:0]   time_reg, time_next, time_inc;
  logic          wrap_reg, wrap_next;
  logic          tick;
  logic          carry;
  logic          hours_max;

  assign tick      = (state_reg == RUN) && (prescaler_reg == PRE_MAX);
  assign hours_max = (time_reg[31:24] == 8'h23);

  // BCD increment of the whole time value; carry ripples digit to digit.
  always_comb begin
    time_inc = time_reg;
    carry    = 1'b1;
    for (int i = 0; i < 6; i++) begin
      if (carry) begin
        if (time_reg[i*4 +: 4] == DIGIT_MAX[i*4 +: 4]) begin
          time_inc[i*4 +: 4] = 4'd0;
        end else begin
          time_inc[i*4 +: 4] = time_reg[i*4 +: 4] + 4'd1;
          carry              = 1'b0;
        end
      end
    end
    if (carry) begin
      if (hours_max) begin
        time_inc[31:24] = 8'h00;
      end else if (time_reg[27:24] == 4'd9) begin
        time_inc[27:24] = 4'd0;
        time_inc[31:28] = time_reg[31:28] + 4'd1;
      end else begin
        time_inc[27:24] = time_reg[27:24] + 4'd1;
      end
    end
  end

  always_comb begin
    state_next     = state_reg;
    prescaler_next = prescaler_reg;
    time_next      = time_reg;
    wrap_next      = 1'b0;
    if (bus.clear) begin
      state_next     = IDLE;
      prescaler_next = '0;
      time_next      = '0;
    end else begin
      if (bus.start_stop) begin
        state_next = (state_reg == RUN) ? PAUSE : RUN;
      end
      if (state_reg == RUN) begin
        prescaler_next = tick ? '0 : prescaler_reg + PW'(1);
      end else if (state_reg == IDLE) begin
        prescaler_next = '0;
      end
      if (tick) begin
        time_next = time_inc;
        wrap_next = carry && hours_max;
      end
    end
  end

  // time_reg is written every cycle so it always follows time_next.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_reg     <= IDLE;
      prescaler_reg <= '0;
      time_reg      <= '0;
      wrap_reg      <= 1'b0;
    end else begin
      state_reg     <= state_next;
      prescaler_reg <= prescaler_next;
      time_reg      <= time_next;
      wrap_reg      <= wrap_next;
    end
  end

  assign bus.running = (state_reg == RUN);
  assign bus.wrap    = wrap_reg;

`ifdef STOPWATCH_LAP_EN
  logic        freeze_reg, freeze_next;
  logic [31:0] snapshot_reg, snapshot_next;

  always_comb begin
    freeze_next   = freeze_reg;
    snapshot_next = snapshot_reg;
    if (bus.clear) begin
      freeze_next = 1'b0;
    end else if (bus.lap) begin
      if (freeze_reg) begin
        freeze_next = 1'b0;
      end else if (state_reg == RUN) begin
        freeze_next   = 1'b1;
        snapshot_next = time_reg;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      freeze_reg   <= 1'b0;
      snapshot_reg <= '0;
    end else begin
      freeze_reg   <= freeze_next;
      snapshot_reg <= snapshot_next;
    end
  end

  assign bus.digits = freeze_reg ? snapshot_reg : time_reg;
`else
  assign bus.digits = time_reg;
`endif

endmodule
